// File: rtl/eeg_chip_tx.sv
// eeg_chip_tx: burst transmitter toward the EEG chip input port.
// Each accepted request sends one command header beat and then req_len
// payload beats. Payload comes from a first-word fall-through FIFO that
// can be preloaded at any time, including while the FSM is idle.
module eeg_chip_tx #(
    parameter int CHIP_DAT_DW = 8,
    parameter int CHIP_CMD_DW = 4,
    parameter int LEN_AW      = 12,
    parameter int FIFO_AW     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_vld,
    output logic                   req_rdy,
    input  logic [CHIP_CMD_DW-1:0] req_cmd,
    input  logic [LEN_AW-1:0]      req_len,
    input  logic                   wdat_vld,
    output logic                   wdat_rdy,
    input  logic [CHIP_DAT_DW-1:0] wdat_dat,
    output logic                   CHIP_DAT_VLD,
    input  logic                   CHIP_DAT_RDY,
    output logic [CHIP_DAT_DW-1:0] CHIP_DAT_DAT,
    output logic                   CHIP_DAT_CMD,
    output logic                   CHIP_DAT_LST,
    output logic                   busy,
    output logic                   burst_done,
    output logic [FIFO_AW:0]       fifo_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    state_e                 state_q, state_d;
    logic [CHIP_CMD_DW-1:0] cmd_q, cmd_d;
    logic [LEN_AW-1:0]      len_q, len_d;
    logic [LEN_AW-1:0]      rem_q, rem_d;
    logic                   done_q, done_d;
    logic                   rst_q;

    logic [CHIP_DAT_DW-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]       cnt_q;

    logic                   quiet;
    logic                   full, empty;
    logic                   push, pop;
    logic                   vld, hdr, lst;
    logic [CHIP_DAT_DW-1:0] dat;

    // All handshakes and outputs are held off during reset and the cycle after.
    assign quiet = rst | rst_q;
    assign full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    // Push is gated by full only, so a pop at full never frees room the same cycle.
    assign push  = wdat_vld && !full && !quiet;

    // Next-state, latched request fields and beat presentation.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        vld     = 1'b0;
        hdr     = 1'b0;
        lst     = 1'b0;
        dat     = '0;
        case (state_q)
            IDLE: begin
                if (req_vld && !quiet) begin
                    cmd_d   = req_cmd;
                    len_d   = req_len;
                    state_d = CMD;
                end
            end
            CMD: begin
                vld = 1'b1;
                hdr = 1'b1;
                dat = CHIP_DAT_DW'(cmd_q);
                lst = (len_q == '0);
                if (CHIP_DAT_RDY) begin
                    if (len_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = len_q;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // An empty FIFO simply stalls the burst with rem held.
                vld = !empty;
                dat = mem_q[rd_ptr_q];
                lst = (rem_q == LEN_AW'(1));
                if (!empty && CHIP_DAT_RDY) begin
                    pop   = 1'b1;
                    rem_d = rem_q - LEN_AW'(1);
                    if (rem_q == LEN_AW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            rst_q   <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (FIFO_AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (FIFO_AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdat_dat;
    end

    assign req_rdy      = !quiet && (state_q == IDLE);
    assign wdat_rdy     = !quiet && !full;
    assign CHIP_DAT_VLD = !quiet && vld;
    assign CHIP_DAT_CMD = !quiet && hdr;
    assign CHIP_DAT_LST = !quiet && lst;
    assign CHIP_DAT_DAT = quiet ? '0 : dat;
    assign busy         = !quiet && (state_q != IDLE);
    assign burst_done   = !rst && done_q;
    assign fifo_cnt     = quiet ? '0 : cnt_q;

endmodule

// File: tb/tb_eeg_chip_tx.sv
// Bench for eeg_chip_tx: directed scenarios plus a random phase. The monitor
// keeps a stream-level model (pending request, queue of pushed payload) and
// compares every DUT output each cycle on the falling edge.
module tb_eeg_chip_tx;
    localparam int DW = 8, CW = 4, LW = 12, FW = 4, DEPTH = 16;

    logic          clk, rst;
    logic          req_vld, req_rdy;
    logic [CW-1:0] req_cmd;
    logic [LW-1:0] req_len;
    logic          wdat_vld, wdat_rdy;
    logic [DW-1:0] wdat_dat;
    logic          CHIP_DAT_VLD, CHIP_DAT_RDY, CHIP_DAT_CMD, CHIP_DAT_LST;
    logic [DW-1:0] CHIP_DAT_DAT;
    logic          busy, burst_done;
    logic [FW:0]   fifo_cnt;

    int checks = 0, errors = 0;

    eeg_chip_tx #(.CHIP_DAT_DW(DW), .CHIP_CMD_DW(CW), .LEN_AW(LW), .FIFO_AW(FW)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_cmd(req_cmd), .req_len(req_len),
        .wdat_vld(wdat_vld), .wdat_rdy(wdat_rdy), .wdat_dat(wdat_dat),
        .CHIP_DAT_VLD(CHIP_DAT_VLD), .CHIP_DAT_RDY(CHIP_DAT_RDY),
        .CHIP_DAT_DAT(CHIP_DAT_DAT), .CHIP_DAT_CMD(CHIP_DAT_CMD), .CHIP_DAT_LST(CHIP_DAT_LST),
        .busy(busy), .burst_done(burst_done), .fifo_cnt(fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Driver controls (payload side and chip ready), written by main only.
    int            push_mode;   // 0 off, 1 from push_list, 2 random, 3 hold constant
    int            rdy_mode;    // 0 always, 1 random, 2 pattern 1,0,0,1, 3 never
    logic [DW-1:0] hold_dat;
    logic [DW-1:0] push_list [$];

    // Payload and chip-ready driver; updates 1 time unit after each rising edge.
    initial begin
        bit acc;
        int pi;
        int pat [4] = '{1, 0, 0, 1};
        pi = 0;
        wdat_vld = 1'b0; wdat_dat = '0; CHIP_DAT_RDY = 1'b0;
        forever begin
            @(negedge clk);
            acc = wdat_vld && wdat_rdy;
            @(posedge clk);
            #1;
            if (acc && push_mode == 1 && push_list.size() > 0) void'(push_list.pop_front());
            case (push_mode)
                1: begin
                    wdat_vld = (push_list.size() > 0);
                    wdat_dat = (push_list.size() > 0) ? push_list[0] : '0;
                end
                2: begin wdat_vld = 1'($urandom_range(0, 1)); wdat_dat = DW'($urandom); end
                3: begin wdat_vld = 1'b1; wdat_dat = hold_dat; end
                default: wdat_vld = 1'b0;
            endcase
            case (rdy_mode)
                0: CHIP_DAT_RDY = 1'b1;
                1: CHIP_DAT_RDY = 1'($urandom_range(0, 1));
                2: begin CHIP_DAT_RDY = (pat[pi % 4] != 0); pi++; end
                default: CHIP_DAT_RDY = 1'b0;
            endcase
        end
    end

    // Scoreboard model state, owned by the monitor.
    logic [DW-1:0] pay_q [$];   // payload accepted into the FIFO, oldest first
    bit            outst, hdr_pend, done_exp, rst_prev, stall_prev;
    logic [CW-1:0] m_cmd;
    int            m_len, m_rem;
    logic [DW-1:0] sv_dat;
    bit            sv_cmd, sv_lst;

    // Monitor: compare outputs against the model, then absorb this cycle's handshakes.
    always @(negedge clk) begin
        bit            blk, expv, ec, el;
        logic [DW-1:0] ed;
        blk = rst || rst_prev;
        if (blk) begin
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_wdat_rdy", wdat_rdy, 0);
            chk("rst_vld", CHIP_DAT_VLD, 0);
            chk("rst_cmd", CHIP_DAT_CMD, 0);
            chk("rst_lst", CHIP_DAT_LST, 0);
            chk("rst_dat", CHIP_DAT_DAT, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", burst_done, 0);
            chk("rst_fifo_cnt", fifo_cnt, 0);
            pay_q.delete();
            outst = 0; hdr_pend = 0; done_exp = 0; stall_prev = 0;
        end else begin
            chk("req_rdy", req_rdy, !outst);
            chk("busy", busy, outst);
            chk("wdat_rdy", wdat_rdy, pay_q.size() < DEPTH);
            chk("fifo_cnt", fifo_cnt, pay_q.size());
            chk("burst_done", burst_done, done_exp);
            expv = 0; ed = '0; ec = 0; el = 0;
            if (outst && hdr_pend) begin
                expv = 1; ed = DW'(m_cmd); ec = 1; el = (m_len == 0);
            end else if (outst && pay_q.size() > 0) begin
                expv = 1; ed = pay_q[0]; el = (m_rem == 1);
            end
            chk("beat_vld", CHIP_DAT_VLD, expv);
            if (expv && CHIP_DAT_VLD) begin
                chk("beat_dat", CHIP_DAT_DAT, ed);
                chk("beat_cmd", CHIP_DAT_CMD, ec);
                chk("beat_lst", CHIP_DAT_LST, el);
            end
            if (stall_prev) begin
                chk("hold_vld", CHIP_DAT_VLD, 1);
                chk("hold_dat", CHIP_DAT_DAT, sv_dat);
                chk("hold_cmd", CHIP_DAT_CMD, sv_cmd);
                chk("hold_lst", CHIP_DAT_LST, sv_lst);
            end
            stall_prev = CHIP_DAT_VLD && !CHIP_DAT_RDY;
            sv_dat = CHIP_DAT_DAT; sv_cmd = CHIP_DAT_CMD; sv_lst = CHIP_DAT_LST;
            done_exp = 0;
            if (expv && CHIP_DAT_VLD && CHIP_DAT_RDY) begin
                if (hdr_pend) begin
                    hdr_pend = 0;
                    if (m_len == 0) begin outst = 0; done_exp = 1; end
                    else m_rem = m_len;
                end else begin
                    void'(pay_q.pop_front());
                    m_rem--;
                    if (m_rem == 0) begin outst = 0; done_exp = 1; end
                end
            end
            if (wdat_vld && wdat_rdy) pay_q.push_back(wdat_dat);
            if (req_vld && req_rdy) begin
                outst = 1; hdr_pend = 1; m_cmd = req_cmd; m_len = int'(req_len);
            end
        end
        rst_prev = rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_req(input logic [CW-1:0] c, input logic [LW-1:0] l);
        bit acc;
        int n;
        acc = 0; n = 0;
        req_vld = 1'b1; req_cmd = c; req_len = l;
        while (!acc) begin
            @(negedge clk);
            acc = req_rdy;
            n++;
            @(posedge clk);
            #2;
            if (!acc && n > 2000) begin chk("req_timeout", acc, 1); break; end
        end
        req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        if (busy) chk("idle_timeout", busy, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_list();
        int n;
        n = 0;
        while (push_list.size() > 0 && n < 2000) begin tick(1); n++; end
        if (push_list.size() > 0) chk("push_timeout", push_list.size(), 0);
        tick(1);
    endtask

    task automatic do_reset();
        push_mode = 0;
        push_list.delete();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_cmd = '0; req_len = '0;
        push_mode = 0; rdy_mode = 0; hold_dat = '0;
        tick(3);
        rst = 1'b0;
        tick(3);

        // Preloaded burst: header 0x05 then 0x11, 0x22, 0x33.
        push_list.push_back(8'h11); push_list.push_back(8'h22); push_list.push_back(8'h33);
        push_mode = 1;
        wait_list();
        send_req(4'h5, 12'd3);
        wait_idle();

        // Header-only burst.
        send_req(4'hA, 12'd0);
        wait_idle();

        // Chip ready toggling 1,0,0,1 across a 5-beat burst.
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) push_list.push_back(DW'($urandom));
        wait_list();
        send_req(4'h3, 12'd4);
        wait_idle();
        rdy_mode = 0;

        // Fill to full, then keep pushing while the burst pops at full.
        rdy_mode = 3;
        for (int i = 0; i < DEPTH + 2; i++) push_list.push_back(DW'($urandom));
        tick(DEPTH + 4);
        push_mode = 0;
        push_list.delete();
        hold_dat = 8'hC3;
        push_mode = 3;
        rdy_mode = 0;
        send_req(4'h6, 12'd2);
        wait_idle();
        tick(2);
        do_reset();

        // Empty FIFO stalls the data phase until a push arrives.
        push_mode = 1;
        send_req(4'h2, 12'd2);
        tick(5);
        push_list.push_back(8'h7E);
        tick(4);
        push_list.push_back(8'h5A);
        wait_idle();

        // Reset after the header and one data beat of a 3-beat burst.
        rdy_mode = 3;
        push_list.push_back(8'h11); push_list.push_back(8'h22); push_list.push_back(8'h33);
        wait_list();
        send_req(4'h9, 12'd3);
        rdy_mode = 0;
        tick(2);
        rdy_mode = 3;
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        rdy_mode = 0;

        // Random traffic: random pushes, random ready, back-to-back requests.
        push_mode = 2;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) send_req(CW'($urandom_range(0, 15)), LW'($urandom_range(0, 6)));
        wait_idle();
        push_mode = 0;
        rdy_mode = 0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeg_chip_tx.md
EEG_CHIP_TX -- requirements
Module: eeg_chip_tx

Interface
REQ-001 SHALL have parameter CHIP_DAT_DW, default 8, chip input beat width.
REQ-002 SHALL have parameter CHIP_CMD_DW, default 4, command code width; must be <= CHIP_DAT_DW.
REQ-003 SHALL have parameter LEN_AW, default 12, burst length width.
REQ-004 SHALL have parameter FIFO_AW, default 4, data FIFO address width (depth 2**FIFO_AW).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_vld, input, 1, burst request valid.
REQ-008 SHALL have port req_rdy, output, 1, burst request accepted when high with req_vld.
REQ-009 SHALL have port req_cmd, input, CHIP_CMD_DW, command code of the burst.
REQ-010 SHALL have port req_len, input, LEN_AW, number of data beats after the header; 0 means header only.
REQ-011 SHALL have port wdat_vld, input, 1, payload push valid.
REQ-012 SHALL have port wdat_rdy, output, 1, payload push ready (FIFO not full).
REQ-013 SHALL have port wdat_dat, input, CHIP_DAT_DW, payload beat.
REQ-014 SHALL have port CHIP_DAT_VLD, output, 1, chip input beat valid.
REQ-015 SHALL have port CHIP_DAT_RDY, input, 1, chip accepts beat.
REQ-016 SHALL have port CHIP_DAT_DAT, output, CHIP_DAT_DW, beat data.
REQ-017 SHALL have port CHIP_DAT_CMD, output, 1, high when the beat is a command header.
REQ-018 SHALL have port CHIP_DAT_LST, output, 1, high on the last beat of a burst.
REQ-019 SHALL have port busy, output, 1, high when the FSM is not IDLE.
REQ-020 SHALL have port burst_done, output, 1, one-cycle pulse, registered, the cycle after a burst's last beat handshake.
REQ-021 SHALL have port fifo_cnt, output, FIFO_AW+1, current FIFO occupancy.

Function
REQ-022 SHALL implement FSM states IDLE, CMD, DATA.
REQ-023 IDLE: req_rdy=1, CHIP_DAT_VLD=0; on req_vld, latch req_cmd and req_len and go to CMD next cycle.
REQ-024 CMD: CHIP_DAT_VLD=1; CHIP_DAT_DAT=req_cmd zero-extended; CHIP_DAT_CMD=1; CHIP_DAT_LST=(len==0).
REQ-025 CMD on handshake: len==0 -> IDLE; else load remaining=len and go to DATA.
REQ-026 DATA: CHIP_DAT_VLD=!fifo_empty; CHIP_DAT_DAT=FIFO head (first-word fall-through); CHIP_DAT_CMD=0; CHIP_DAT_LST=(remaining==1).
REQ-027 DATA on handshake: pop FIFO, decrement remaining; on the last beat go to IDLE.
REQ-028 req_rdy SHALL be 0 in CMD and DATA; a new request takes effect only after the current burst returns to IDLE, so a header follows the previous last beat after at least 1 idle cycle.
REQ-029 While CHIP_DAT_VLD=1 and CHIP_DAT_RDY=0, CHIP_DAT_DAT, CHIP_DAT_CMD and CHIP_DAT_LST SHALL stay stable and VLD SHALL not drop.
REQ-030 The FIFO SHALL accept a push when wdat_vld && wdat_rdy, in any state, including IDLE, so payload can be preloaded.
REQ-031 wdat_rdy SHALL equal !full; when full, a same-cycle pop SHALL NOT enable a push.
REQ-032 A simultaneous push and pop SHALL keep fifo_cnt unchanged; pointers SHALL wrap modulo depth.
REQ-033 An empty FIFO in DATA SHALL stall: VLD=0 and remaining held, with no underflow.
REQ-034 Latency SHALL be: request accepted at cycle N -> header VLD at cycle N+1; FIFO head visible on CHIP_DAT_DAT the cycle after push.

Reset
REQ-035 While rst=1, the state SHALL go to IDLE, FIFO pointers and fifo_cnt SHALL go to 0, and remaining, len and cmd registers SHALL clear.
REQ-036 While rst=1 and the cycle after, the outputs SHALL be req_rdy=0, wdat_rdy=0, CHIP_DAT_VLD=0, CHIP_DAT_CMD=0, CHIP_DAT_LST=0, busy=0, burst_done=0, fifo_cnt=0, CHIP_DAT_DAT=0.
REQ-037 Reset during a burst SHALL abort it, discard the FIFO contents and produce no burst_done.

Verification
REQ-038 Preload 3 beats (0x11,0x22,0x33), then req cmd=0x5 len=3 with RDY=1 -> beats 0x05(CMD=1), 0x11, 0x22, 0x33(LST=1), then burst_done one cycle later.
REQ-039 Request cmd=0xA len=0 -> single beat 0x0A with CMD=1 and LST=1; the FSM returns to IDLE; burst_done pulses.
REQ-040 len=4 with RDY toggling 1,0,0,1 -> every beat held stable during stalls; 5 beats delivered in order, with no duplicates or drops.
REQ-041 Fill the FIFO to 16 -> wdat_rdy=0; push+pop in the same cycle at full -> fifo_cnt=15, and the push is rejected.
REQ-042 len=2 with the FIFO empty -> header sent, then VLD=0 until a push; the pushed beat 0x7E appears the next cycle.
REQ-043 Assert rst mid-DATA after 1 of 3 beats -> all outputs return to their reset values, fifo_cnt=0, and there is no burst_done.
